// File: rtl/unidade_load_store.sv
// unidade_load_store: load/store unit sitting in front of a word-wide data
// memory with synchronous read and write. It turns CPU byte/half/word
// accesses at byte addresses into word accesses. Sub-word stores are done
// as read-modify-write, and loads are lane-extracted and then sign- or
// zero-extended.
//
// Ports
//   Clock, Reset_n                 clock (rising edge), async active-low reset
//   Req_Read, Req_Write            load / store request, sampled in IDLE
//   Endereco, Tipo, Sem_Sinal      byte address, size (00 b, 01 h, 10 w), zero-extend
//   Dado_Escrita                   store data (sub-word stores use the low bits)
//   Ocupado, Pronto                busy flag, one-cycle completion pulse
//   Dado_Lido                      extended load result, held until the next load
//   Erro_Alinhamento               one-cycle error pulse
//   Mem_Read, Mem_Write            memory enables
//   Endereco_leitura/escrita       memory word addresses
//   Write_Data, Read_Data          memory data (Read_Data valid the cycle after Mem_Read)
//
// Build option: define LSU_ALIGN_TRAP_EN to make misaligned accesses signal
// Erro_Alinhamento instead of executing. Without it, they are force-aligned.
//
// state    | meaning
// IDLE     | waiting for a request
// ISSUE_RD | Mem_Read asserted for the latched word
// CAPTURE  | Read_Data valid: finish the load or merge the store lane
// WRITE    | Mem_Write asserted with the final word

module unidade_load_store #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Req_Read,
  input  logic                  Req_Write,
  input  logic [31:0]           Endereco,
  input  logic [1:0]            Tipo,
  input  logic                  Sem_Sinal,
  input  logic [DATA_WIDTH-1:0] Dado_Escrita,
  output logic                  Ocupado,
  output logic                  Pronto,
  output logic [DATA_WIDTH-1:0] Dado_Lido,
  output logic                  Erro_Alinhamento,
  output logic                  Mem_Read,
  output logic                  Mem_Write,
  output logic [ADDR_WIDTH-1:0] Endereco_leitura,
  output logic [ADDR_WIDTH-1:0] Endereco_escrita,
  output logic [DATA_WIDTH-1:0] Write_Data,
  input  logic [DATA_WIDTH-1:0] Read_Data
);

  typedef enum logic [1:0] {IDLE, ISSUE_RD, CAPTURE, WRITE} state_t;

  state_t                state_q;
  logic                  is_store_q;
  logic [1:0]            tipo_q;
  logic [1:0]            off_q;
  logic                  sem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  pronto_q, erro_q, mem_read_q, mem_write_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
  logic [DATA_WIDTH-1:0] write_data_q, dado_lido_q;

  logic                  req;
  logic                  misaligned;
  logic [1:0]            off_al;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] lane_shifted;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;
  logic                  unused_addr;

  assign word_addr   = Endereco[ADDR_WIDTH+1:2];
  assign unused_addr = ^Endereco[31:ADDR_WIDTH+2];

  always_comb begin
    req        = Req_Read | Req_Write;
    misaligned = ((Tipo == 2'b01) && Endereco[0]) ||
                 ((Tipo == 2'b10) && (Endereco[1:0] != 2'b00));
    // The aligned offset is used when the trap is off. When the trap is on,
    // a misaligned access never gets latched, so the forcing is harmless.
    off_al = Endereco[1:0];
    if (Tipo == 2'b01) off_al = {Endereco[1], 1'b0};
    if (Tipo == 2'b10) off_al = 2'b00;
  end

  // Load path: shift the addressed lane down to bit 0, then extend it.
  always_comb begin
    lane_shifted = Read_Data >> {off_q, 3'b000};
    load_ext     = Read_Data;
    case (tipo_q)
      2'b00:   load_ext = {{24{~sem_q & lane_shifted[7]}},  lane_shifted[7:0]};
      2'b01:   load_ext = {{16{~sem_q & lane_shifted[15]}}, lane_shifted[15:0]};
      default: load_ext = Read_Data;
    endcase
  end

  // Store path: replace only the addressed lane of the word that was read.
  always_comb begin
    merged = Read_Data;
    case (tipo_q)
      2'b00: begin
        case (off_q)
          2'b00: merged[7:0]   = data_q[7:0];
          2'b01: merged[15:8]  = data_q[7:0];
          2'b10: merged[23:16] = data_q[7:0];
          2'b11: merged[31:24] = data_q[7:0];
        endcase
      end
      2'b01: begin
        if (off_q[1]) merged[31:16] = data_q[15:0];
        else          merged[15:0]  = data_q[15:0];
      end
      default: merged = data_q;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      tipo_q       <= 2'b00;
      off_q        <= 2'b00;
      sem_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      pronto_q     <= 1'b0;
      erro_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      write_data_q <= '0;
      dado_lido_q  <= '0;
    end else begin
      pronto_q    <= 1'b0;
      erro_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (Tipo == 2'b11) begin
              erro_q <= 1'b1;
            end
`ifdef LSU_ALIGN_TRAP_EN
            else if (misaligned) begin
              erro_q <= 1'b1;
            end
`endif
            else begin
              is_store_q <= Req_Write;
              tipo_q     <= Tipo;
              off_q      <= off_al;
              sem_q      <= Sem_Sinal;
              addr_q     <= word_addr;
              data_q     <= Dado_Escrita;
              if (Req_Write && (Tipo == 2'b10)) begin
                state_q      <= WRITE;
                mem_write_q  <= 1'b1;
                wr_addr_q    <= word_addr;
                write_data_q <= Dado_Escrita;
              end else begin
                state_q    <= ISSUE_RD;
                mem_read_q <= 1'b1;
                rd_addr_q  <= word_addr;
              end
            end
          end
        end
        ISSUE_RD: state_q <= CAPTURE;
        CAPTURE: begin
          if (is_store_q) begin
            state_q      <= WRITE;
            mem_write_q  <= 1'b1;
            wr_addr_q    <= addr_q;
            write_data_q <= merged;
          end else begin
            state_q     <= IDLE;
            dado_lido_q <= load_ext;
            pronto_q    <= 1'b1;
          end
        end
        WRITE: begin
          state_q  <= IDLE;
          pronto_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Ocupado          = (state_q != IDLE);
  assign Pronto           = pronto_q;
  assign Dado_Lido        = dado_lido_q;
  assign Erro_Alinhamento = erro_q;
  assign Mem_Read         = mem_read_q;
  assign Mem_Write        = mem_write_q;
  assign Endereco_leitura = rd_addr_q;
  assign Endereco_escrita = wr_addr_q;
  assign Write_Data       = write_data_q;

  // misaligned is only consulted when the trap is built in
  logic unused_misaligned;
  assign unused_misaligned = misaligned;

endmodule

// File: tb/tb_unidade_load_store.sv
module tb_unidade_load_store;

  logic        Clock, Reset_n;
  logic        Req_Read, Req_Write;
  logic [31:0] Endereco;
  logic [1:0]  Tipo;
  logic        Sem_Sinal;
  logic [31:0] Dado_Escrita;
  logic        Ocupado, Pronto, Erro_Alinhamento, Mem_Read, Mem_Write;
  logic [31:0] Dado_Lido, Write_Data, Read_Data;
  logic [15:0] Endereco_leitura, Endereco_escrita;

  unidade_load_store #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Req_Read(Req_Read), .Req_Write(Req_Write),
    .Endereco(Endereco), .Tipo(Tipo), .Sem_Sinal(Sem_Sinal), .Dado_Escrita(Dado_Escrita),
    .Ocupado(Ocupado), .Pronto(Pronto), .Dado_Lido(Dado_Lido),
    .Erro_Alinhamento(Erro_Alinhamento), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Endereco_leitura(Endereco_leitura), .Endereco_escrita(Endereco_escrita),
    .Write_Data(Write_Data), .Read_Data(Read_Data)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // data memory: synchronous read and write on the same clock
  logic [31:0] mem [0:65535];
  always @(posedge Clock) begin
    if (Mem_Read)  Read_Data <= mem[Endereco_leitura];
    if (Mem_Write) mem[Endereco_escrita] <= Write_Data;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // per-transaction observations: first cycle (1-based after acceptance) of
  // each event, -1 if it never happened, plus pulse counts
  int          c_rd, c_wr, c_pr, c_er;
  int          n_rd, n_wr, n_pr, n_busy, overlap;
  logic [31:0] ra, wa, wd;

  task run(input logic wr, input logic rd, input logic [31:0] a, input logic [1:0] t,
           input logic s, input logic [31:0] d, input int hold);
    @(negedge Clock);
    Req_Write = wr; Req_Read = rd; Endereco = a; Tipo = t; Sem_Sinal = s; Dado_Escrita = d;
    @(posedge Clock); #1;
    if (hold == 0) begin Req_Write = 1'b0; Req_Read = 1'b0; end
    c_rd = -1; c_wr = -1; c_pr = -1; c_er = -1;
    n_rd = 0; n_wr = 0; n_pr = 0; n_busy = 0; overlap = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clock);
      if (Mem_Read && Mem_Write) overlap++;
      if (Ocupado) n_busy++;
      if (Mem_Read) begin
        n_rd++;
        if (c_rd < 0) begin c_rd = k; ra = 32'(Endereco_leitura); end
      end
      if (Mem_Write) begin
        n_wr++;
        if (c_wr < 0) begin c_wr = k; wa = 32'(Endereco_escrita); wd = Write_Data; end
      end
      if (Pronto) begin n_pr++; if (c_pr < 0) c_pr = k; end
      if (Erro_Alinhamento && c_er < 0) c_er = k;
      if (k == hold) begin Req_Write = 1'b0; Req_Read = 1'b0; end
    end
    check("rd_wr_exclusive", overlap, 0);
  endtask

  int n_wr_rst;

  initial begin
    Reset_n = 1'b0; Req_Read = 1'b0; Req_Write = 1'b0; Endereco = '0;
    Tipo = 2'b00; Sem_Sinal = 1'b0; Dado_Escrita = '0;
    repeat (2) @(negedge Clock);
    check("rst_ocupado", Ocupado, 0);
    check("rst_pronto", Pronto, 0);
    check("rst_dado_lido", Dado_Lido, 0);
    check("rst_erro", Erro_Alinhamento, 0);
    check("rst_mem_en", {Mem_Read, Mem_Write}, 0);
    check("rst_addrs", {Endereco_leitura, Endereco_escrita}, 0);
    check("rst_write_data", Write_Data, 0);
    Reset_n = 1'b1;

    // 1: word store then word load
    run(1, 0, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0);
    check("ws_wr_cycle", c_wr, 1);
    check("ws_wr_addr", wa, 4);
    check("ws_wr_data", wd, 32'hDEADBEEF);
    check("ws_no_read", n_rd, 0);
    check("ws_pronto_cycle", c_pr, 2);
    check("ws_mem4", mem[4], 32'hDEADBEEF);
    run(0, 1, 32'h10, 2'b10, 0, 0, 0);
    check("wl_rd_cycle", c_rd, 1);
    check("wl_rd_addr", ra, 4);
    check("wl_pronto_cycle", c_pr, 3);
    check("wl_busy_cycles", n_busy, 2);
    check("wl_data", Dado_Lido, 32'hDEADBEEF);

    // 2: byte store over 0x11223344, byte loads
    run(1, 0, 32'h10, 2'b10, 0, 32'h11223344, 0);
    run(1, 0, 32'h13, 2'b00, 0, 32'h000000AB, 0);
    check("bs_rd_cycle", c_rd, 1);
    check("bs_wr_cycle", c_wr, 3);
    check("bs_pronto_cycle", c_pr, 4);
    check("bs_mem4", mem[4], 32'hAB223344);
    run(0, 1, 32'h13, 2'b00, 0, 0, 0);
    check("bl_signed", Dado_Lido, 32'hFFFFFFAB);
    run(0, 1, 32'h13, 2'b00, 1, 0, 0);
    check("bl_unsigned", Dado_Lido, 32'h000000AB);

    // 3: halfword store and loads
    run(1, 0, 32'h12, 2'b01, 0, 32'h00008001, 0);
    check("hs_wr_data", wd, 32'h80013344);
    check("hs_mem4", mem[4], 32'h80013344);
    run(0, 1, 32'h12, 2'b01, 0, 0, 0);
    check("hl_hi_signed", Dado_Lido, 32'hFFFF8001);
    run(0, 1, 32'h10, 2'b01, 1, 0, 0);
    check("hl_lo_unsigned", Dado_Lido, 32'h00003344);

    // 4: misaligned halfword load, misaligned word store
    run(0, 1, 32'h11, 2'b01, 1, 0, 0);
`ifdef LSU_ALIGN_TRAP_EN
    check("mis_h_erro_cycle", c_er, 1);
    check("mis_h_no_read", n_rd, 0);
    check("mis_h_no_pronto", n_pr, 0);
    check("mis_h_not_busy", n_busy, 0);
`else
    check("mis_h_rd_addr", ra, 4);
    check("mis_h_data", Dado_Lido, 32'h00003344);
    check("mis_h_no_erro", c_er, -1);
    check("mis_h_pronto_cycle", c_pr, 3);
`endif
    run(1, 0, 32'h23, 2'b10, 0, 32'h12345678, 0);
`ifdef LSU_ALIGN_TRAP_EN
    check("mis_w_erro_cycle", c_er, 1);
    check("mis_w_no_write", n_wr, 0);
`else
    check("mis_w_wr_addr", wa, 8);
    check("mis_w_mem8", mem[8], 32'h12345678);
    check("mis_w_no_erro", c_er, -1);
`endif

    // illegal size: error pulse only, Dado_Lido untouched
    run(0, 1, 32'h10, 2'b11, 0, 0, 0);
    check("ill_erro_cycle", c_er, 1);
    check("ill_no_access", n_rd + n_wr, 0);
    check("ill_no_pronto", n_pr, 0);
    check("ill_dado_held", Dado_Lido, 32'h00003344);

    // 5: reset while in CAPTURE of a byte store
    @(negedge Clock);
    Req_Write = 1'b1; Endereco = 32'h10; Tipo = 2'b00; Dado_Escrita = 32'h000000EE;
    @(posedge Clock); #1;
    Req_Write = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b0;
    #1;
    check("rstc_ocupado", Ocupado, 0);
    check("rstc_outputs", {Pronto, Erro_Alinhamento, Mem_Read, Mem_Write}, 0);
    check("rstc_dado_lido", Dado_Lido, 0);
    check("rstc_write_data", Write_Data, 0);
    check("rstc_addrs", {Endereco_leitura, Endereco_escrita}, 0);
    n_wr_rst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      if (k == 1) Reset_n = 1'b1;
      if (Mem_Write) n_wr_rst++;
    end
    check("rstc_no_write", n_wr_rst, 0);
    check("rstc_mem4", mem[4], 32'h80013344);

    // 6: simultaneous requests, then requests held while busy
    run(1, 1, 32'h10, 2'b10, 0, 32'h55AA55AA, 0);
    check("both_no_read", n_rd, 0);
    check("both_wr_cycle", c_wr, 1);
    check("both_mem4", mem[4], 32'h55AA55AA);
    run(0, 1, 32'h10, 2'b10, 0, 0, 2);
    check("busy_one_read", n_rd, 1);
    check("busy_one_pronto", n_pr, 1);
    check("busy_data", Dado_Lido, 32'h55AA55AA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule

// File: doc/unidade_load_store.md
Name: unidade_load_store

Overview:
- Load/store unit directly upstream of the data memory. The data memory is word-wide, has synchronous read and write, and is instantiated with both of its clocks tied to Clock.
- Converts CPU byte, halfword and word accesses at byte addresses into word accesses on the memory.
- Sub-word stores use read-modify-write.
- Loads are extracted from the returned word and sign- or zero-extended.

Parameters:
- DATA_WIDTH, 32, CPU and memory word width; only 32 is supported.
- ADDR_WIDTH, 16, memory word-address width.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Req_Read  in  1  load request, sampled in IDLE.
- Req_Write  in  1  store request, sampled in IDLE.
- Endereco  in  32  CPU byte address.
- Tipo  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- Sem_Sinal  in  1  1 = zero-extend load, 0 = sign-extend load.
- Dado_Escrita  in  32  store data; sub-word stores use the low bits.
- Ocupado  out  1  unit busy; requests are ignored while high.
- Pronto  out  1  one-cycle completion pulse.
- Dado_Lido  out  32  extended load result; holds its value until the next load completes.
- Erro_Alinhamento  out  1  one-cycle error pulse.
- Mem_Read  out  1  memory read enable.
- Mem_Write  out  1  memory write enable.
- Endereco_leitura  out  ADDR_WIDTH  memory read word address.
- Endereco_escrita  out  ADDR_WIDTH  memory write word address.
- Write_Data  out  32  memory write data.
- Read_Data  in  32  memory read data; valid the cycle after Mem_Read.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - Every output is 0: Ocupado, Pronto, Dado_Lido, Erro_Alinhamento, Mem_Read, Mem_Write, both addresses, Write_Data.
  - A pending store is discarded; memory is never written.
- Word address = Endereco[ADDR_WIDTH+1:2]. Upper bits are ignored. Byte offset = Endereco[1:0].
- Lanes are little-endian: offset 0 maps to bits 7:0. A halfword at offset 2 maps to bits 31:16.
- Ocupado = (state != IDLE).
- Acceptance, in IDLE only:
  - Req_Write has priority; a simultaneous Req_Read is dropped.
  - On acceptance, address, Tipo, Sem_Sinal, data and operation are latched.
- States:
  - IDLE: word store -> WRITE; load or sub-word store -> ISSUE_RD; no request -> IDLE.
  - ISSUE_RD: Mem_Read=1 with Endereco_leitura = latched word address. Next state is CAPTURE.
  - CAPTURE, load: Dado_Lido <= extracted lane, extended per Sem_Sinal; Pronto=1 next cycle; -> IDLE.
  - CAPTURE, store: merge register <= Read_Data with the store lane replaced; -> WRITE.
  - WRITE: Mem_Write=1, Endereco_escrita = latched word address, Write_Data = merged word (or Dado_Escrita for a word store). Pronto=1 next cycle; -> IDLE.
- Latency, with acceptance at cycle 0:
  - Load: Mem_Read in cycle 1, Pronto in cycle 3.
  - Word store: Mem_Write in cycle 1, Pronto in cycle 2.
  - Sub-word store: Mem_Read in cycle 1, Mem_Write in cycle 3, Pronto in cycle 4.
- Mem_Read and Mem_Write are never high in the same cycle.
- Outside ISSUE_RD and WRITE respectively, both enables are 0. Addresses and Write_Data hold their last values.
- A new request can be accepted in the same cycle that Pronto is high (back-to-back).
- Tipo=11: never accepted as an access. Erro_Alinhamento pulses in cycle 1, no memory access is made, Pronto stays 0.
- Misaligned access (half with Endereco[0]=1; word with Endereco[1:0]!=0): handled per LSU_ALIGN_TRAP_EN.

Optional Feature:
- Macro: LSU_ALIGN_TRAP_EN.
- Defined: a misaligned request is consumed but not executed.
  - No Mem_Read or Mem_Write.
  - Erro_Alinhamento pulses in cycle 1.
  - Pronto stays 0 and the unit remains in IDLE.
- Undefined: the misaligned address is force-aligned (half: bit0 cleared; word: bits 1:0 cleared) and executed normally.
  - Erro_Alinhamento only ever pulses for Tipo=11.

Test Plan:
1. Word store 0xDEADBEEF at 0x00000010, then word load at 0x10 -> Mem_Write in cycle 1 at word address 4, Pronto in cycle 2; load gives Dado_Lido=0xDEADBEEF with Pronto in cycle 3.
2. Memory word 4 = 0x11223344; byte store 0xAB at 0x13 -> word becomes 0xAB223344, Pronto in cycle 4. Byte load 0x13 with Sem_Sinal=0 -> 0xFFFFFFAB; with Sem_Sinal=1 -> 0x000000AB.
3. Half store 0x8001 at 0x12 over 0xAB223344 -> 0x80013344. Half load 0x12 signed -> 0xFFFF8001. Half load 0x10 unsigned -> 0x00003344.
4. Half load at 0x11:
   - With LSU_ALIGN_TRAP_EN -> Erro_Alinhamento pulse in cycle 1, no Mem_Read, Pronto stays 0.
   - Without it -> reads word 4 at offset 0, Dado_Lido = 0x00003344 when Sem_Sinal=1.
5. Reset_n low during CAPTURE of a byte store -> Ocupado and all outputs 0 immediately, Mem_Write never asserts, memory word unchanged.
6. Req_Read and Req_Write together in IDLE -> only the store executes. A request while Ocupado=1 -> ignored: no extra memory access, no extra Pronto.
